// File: rtl/part_74f259_sync_pkg.sv
// Shared definitions for the synchronous 74F259 addressable register.
// Mode encoding is {MR_N, E_N}, matching the pin-level truth table.
package part_74f259_sync_pkg;

    localparam int SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        MODE_DEMUX = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

endpackage

// File: rtl/part_mod_counter.sv
// Modulo-2**W up-counter with enable, synchronous clear and terminal count.
// o_tc flags an enabled count from the all-ones value, i.e. the wrap edge.
module part_mod_counter #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Reset and clear both return to zero; otherwise advance when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = i_en && (r_cnt == {W{1'b1}});

endmodule

// File: rtl/part_74f259_sync.sv
// Clocked 8-bit addressable latch (74F259 function) with an auto-increment
// address counter for rebuilding a serial bit stream into a parallel byte.
module part_74f259_sync
    import part_74f259_sync_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int NOUT  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic [SEL_W-1:0] S,
    input  logic             E_N,
    input  logic             MR_N,
    input  logic             AI,
    output logic [NOUT-1:0]  Q,
    output logic [SEL_W-1:0] CNT,
    output logic             FULL
);

    logic [NOUT-1:0]  r_q;
    logic             r_full;
    logic [SEL_W-1:0] w_cnt;
    logic             w_tc;
    logic [SEL_W-1:0] w_addr;
    logic [NOUT-1:0]  w_dec;
    logic [NOUT-1:0]  w_dbits;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    mode_e            w_mode;

    assign w_mode    = mode_e'({MR_N, E_N});
    assign w_cnt_en  = !E_N && AI;
    assign w_cnt_clr = (w_mode == MODE_CLEAR);
    assign w_addr    = AI ? w_cnt : S;
    assign w_dec     = NOUT'(1) << w_addr;
    assign w_dbits   = D ? w_dec : '0;

    part_mod_counter #(
        .W (SEL_W)
    ) u_cnt (
        .i_clk (CLK),
        .i_rst (RST),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Output register: addressed write, hold, one-hot decode, or clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
        end else begin
            case (w_mode)
                MODE_WRITE: r_q <= (r_q & ~w_dec) | w_dbits;
                MODE_HOLD:  r_q <= r_q;
                MODE_DEMUX: r_q <= w_dbits;
                MODE_CLEAR: r_q <= '0;
                default:    r_q <= r_q;
            endcase
        end
    end

    // Byte-complete strobe: one cycle after the counter wraps on a write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_full <= 1'b0;
        end else begin
            r_full <= w_tc;
        end
    end

    assign Q    = r_q;
    assign CNT  = w_cnt;
    assign FULL = r_full;

endmodule

// File: tb/tb_part_74f259_sync.sv
// Directed bench for part_74f259_sync with hand-computed expected values.
module tb_part_74f259_sync;

    logic       CLK;
    logic       RST;
    logic       D;
    logic [2:0] S;
    logic       E_N;
    logic       MR_N;
    logic       AI;
    logic [7:0] Q;
    logic [2:0] CNT;
    logic       FULL;

    int n_checks = 0;
    int n_pass   = 0;

    part_74f259_sync #(.SEL_W(3), .NOUT(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .D    (D),
        .S    (S),
        .E_N  (E_N),
        .MR_N (MR_N),
        .AI   (AI),
        .Q    (Q),
        .CNT  (CNT),
        .FULL (FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic [2:0] ec, input logic ef);
        check({tag, " Q"}, 32'(Q), 32'(eq));
        check({tag, " CNT"}, 32'(CNT), 32'(ec));
        check({tag, " FULL"}, 32'(FULL), 32'(ef));
    endtask

    initial begin
        logic [7:0] pat;

        RST = 1'b1; D = 1'b0; S = 3'd0; E_N = 1'b1; MR_N = 1'b1; AI = 1'b0;
        step();
        chk_all("reset_init", 8'h00, 3'd0, 1'b0);
        RST = 1'b0;

        // Addressable write with S
        MR_N = 1'b1; AI = 1'b0; E_N = 1'b0;
        D = 1'b1; S = 3'd2; step(); check("wr_s2", 32'(Q), 32'h04);
        D = 1'b1; S = 3'd5; step(); check("wr_s5", 32'(Q), 32'h24);
        D = 1'b0; S = 3'd2; step(); check("wr_s2_clr", 32'(Q), 32'h20);
        E_N = 1'b1;
        D = 1'b1; S = 3'd7; step(); check("hold1", 32'(Q), 32'h20);
        D = 1'b0; S = 3'd5; step(); check("hold2", 32'(Q), 32'h20);
        check("s_writes_no_cnt", 32'(CNT), 32'd0);

        // Reset dominates an active demux write
        RST = 1'b1; E_N = 1'b0; MR_N = 1'b0; D = 1'b1; S = 3'd3;
        step();
        chk_all("reset_busy", 8'h00, 3'd0, 1'b0);
        RST = 1'b0;

        // Demux mode from an all-ones preload
        MR_N = 1'b1; E_N = 1'b0; AI = 1'b0; D = 1'b1;
        for (int i = 0; i < 8; i++) begin
            S = 3'(i);
            step();
        end
        check("preload_ff", 32'(Q), 32'hFF);
        MR_N = 1'b0; E_N = 1'b0; S = 3'd6; D = 1'b1; step();
        check("demux_s6", 32'(Q), 32'h40);
        D = 1'b0; S = 3'd3; step();
        check("demux_zero", 32'(Q), 32'h00);

        // Build Q=A5, CNT=4, then clear mode
        MR_N = 1'b1; E_N = 1'b0; AI = 1'b1;
        D = 1'b1; step();
        D = 1'b0; step();
        D = 1'b1; step();
        D = 1'b0; step();
        AI = 1'b0;
        D = 1'b1; S = 3'd5; step();
        D = 1'b1; S = 3'd7; step();
        check("pre_clear Q", 32'(Q), 32'hA5);
        check("pre_clear CNT", 32'(CNT), 32'd4);
        MR_N = 1'b0; E_N = 1'b1; step();
        chk_all("clear", 8'h00, 3'd0, 1'b0);

        // Auto-increment deserialise 0xA5
        MR_N = 1'b1; E_N = 1'b0; AI = 1'b1;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            D = pat[i];
            step();
            check("deser_full", 32'(FULL), (i == 7) ? 32'd1 : 32'd0);
        end
        chk_all("deser_done", 8'hA5, 3'd0, 1'b1);
        E_N = 1'b1; step();
        chk_all("deser_after", 8'hA5, 3'd0, 1'b0);

        // AI toggle mid-byte keeps CNT
        E_N = 1'b0; AI = 1'b1; D = 1'b0;
        step(); step(); step();
        check("ai_cnt3", 32'(CNT), 32'd3);
        AI = 1'b0; S = 3'd6; D = 1'b1; step();
        check("ai_off_cnt", 32'(CNT), 32'd3);
        check("ai_off_q", 32'(Q), 32'hE0);
        AI = 1'b1; D = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("cnt7", 32'(CNT), 32'd7);
        check("cnt7_nofull", 32'(FULL), 32'd0);
        // Demux write at the wrap point still raises FULL
        MR_N = 1'b0; D = 1'b1; step();
        chk_all("demux_wrap", 8'h80, 3'd0, 1'b1);

        // Mid-byte reset then reassemble 0x3C
        MR_N = 1'b1; E_N = 1'b0; AI = 1'b1; D = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("mid_cnt5", 32'(CNT), 32'd5);
        RST = 1'b1; step();
        chk_all("mid_reset", 8'h00, 3'd0, 1'b0);
        RST = 1'b0;
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            D = pat[i];
            step();
            check("post_rst_full", 32'(FULL), (i == 7) ? 32'd1 : 32'd0);
        end
        chk_all("post_rst_done", 8'h3C, 3'd0, 1'b1);
        E_N = 1'b1; step();
        check("post_rst_strobe_end", 32'(FULL), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
